// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4
//   1:4 time-division demultiplexer. Words arrive on a single shared lane in
//   slot order 0..3, with slot 0 marked by sof. Slots 0..2 are parked in shadow
//   registers. The slot-3 word is merged with them so that all four channel
//   outputs update together, and only when a complete frame has been received.
//
// Ports
//   clk          in   1          system clock, rising edge
//   rst_n        in   1          asynchronous active-low reset (released synchronously inside)
//   din          in   WIDTH      lane data for the current slot
//   din_valid    in   1          din qualifies this cycle
//   sof          in   1          start of frame: din is slot 0 (ignored when din_valid=0)
//   y            out  4*WIDTH    channel words; y[k*WIDTH +: WIDTH] = channel k
//   s            out  2          slot index the next valid word is written to (0 in IDLE)
//   frame_valid  out  1          1-cycle pulse: y was just loaded with a complete frame
//   sync_err     out  1          1-cycle pulse: sof arrived before the frame completed
// -----------------------------------------------------------------------------
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 sof,
    output logic [4*WIDTH-1:0]   y,
    output logic [1:0]           s,
    output logic                 frame_valid,
    output logic                 sync_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shadow [3];
    logic [1:0]         rst_sync;
    logic               rst_int_n;

    // Reset asserts asynchronously and is released on a clock edge, so every
    // flop leaves reset in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // NOTE: all state below is written with non-blocking assignments so that
    // every branch reads the pre-edge values of s and shadow[].
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state       <= IDLE;
            s           <= 2'd0;
            y           <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            // NOTE: the shadow registers are only three words, so clearing
            // them in reset is cheap and keeps the reset state fully defined.
            for (int i = 0; i < 3; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            // Flags are pulses: cleared every cycle unless an event sets them.
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;

            if (din_valid) begin
                unique case (state)
                    IDLE: begin
                        // A word without sof here belongs to no frame: drop it.
                        if (sof) begin
                            shadow[0] <= din;
                            s         <= 2'd1;
                            state     <= RUN;
                        end
                    end

                    RUN: begin
                        if (sof) begin
                            // Early sof: abandon the partial frame and resync.
                            sync_err  <= 1'b1;
                            shadow[0] <= din;
                            s         <= 2'd1;
                        end else begin
                            unique case (s)
                                2'd1: shadow[1] <= din;
                                2'd2: shadow[2] <= din;
                                2'd3: begin
                                    // Slot 3 bypasses the shadows straight into y.
                                    y           <= {din, shadow[2], shadow[1], shadow[0]};
                                    frame_valid <= 1'b1;
                                    state       <= IDLE;
                                end
                                default: shadow[0] <= din;
                            endcase
                            s <= s + 2'd1;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
